// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin operand-mux arbiter.
package mux_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NUM_REQ = 4;

  // Increment with explicit wrap so non-power-of-two counts never overflow
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Requester-side and consumer-side handshake bundle of the arbiter.
// req_lock exists only when MUX_ARB_LOCK_EN is defined.
interface mux16_rr_arbiter_if #(
  parameter int WIDTH   = mux_arb_pkg::DEF_WIDTH,
  parameter int NUM_REQ = mux_arb_pkg::DEF_NUM_REQ
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
`ifdef MUX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]            req_lock;
`endif
  logic                          out_valid;
  logic [WIDTH-1:0]              out_data;
  logic [IDX_W-1:0]              out_src;
  logic                          out_ready;
  logic                          busy;

  // Arbiter side
  modport master (
    input  req_valid, req_data, out_ready,
`ifdef MUX_ARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready, out_valid, out_data, out_src, busy
  );

  // Requesters and consumer side
  modport slave (
    output req_valid, req_data, out_ready,
`ifdef MUX_ARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready, out_valid, out_data, out_src, busy
  );

endinterface

// File: rtl/mux16_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first valid index at or above ptr,
// wrapping N-1 -> 0. Returns one-hot grant, index and any-valid flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vld,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic found;

  // Scan N positions starting at ptr; first hit wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    any   = |vld;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && vld[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter feeding a single output register through the shared
// operand mux. Optional grant locking under MUX_ARB_LOCK_EN.
module mux16_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic           clk,
  input  logic           rst_n,
  mux16_rr_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_src_q, out_src_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [IDX_W-1:0]   search_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               any_vld;
  logic               load;

`ifdef MUX_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic hold_live;

  // While the holder keeps valid+lock it is searched first; once it lets go
  // the search restarts just past it
  always_comb begin
    hold_live  = bus.req_valid[rr_ptr_q] && bus.req_lock[rr_ptr_q];
    search_ptr = (lock_q && !hold_live) ? IDX_W'(next_idx(int'(rr_ptr_q), NUM_REQ))
                                        : rr_ptr_q;
  end
`else
  assign search_ptr = rr_ptr_q;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .vld (bus.req_valid),
    .ptr (search_ptr),
    .gnt (gnt),
    .idx (win_idx),
    .any (any_vld)
  );

  // Gated by rst_n so no handshake completes while reset is held
  assign load          = rst_n && any_vld && (state_q == EMPTY || bus.out_ready);
  assign bus.req_ready = load ? gnt : '0;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = (state_q == FULL) || (|bus.req_valid);

  // Next-state, output register and pointer update
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    rr_ptr_d   = rr_ptr_q;
`ifdef MUX_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (!load && bus.out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (load) begin
      out_data_d = bus.req_data[win_idx];
      out_src_d  = win_idx;
`ifdef MUX_ARB_LOCK_EN
      if (bus.req_lock[win_idx]) begin
        rr_ptr_d = win_idx;
        lock_d   = 1'b1;
      end else begin
        rr_ptr_d = IDX_W'(next_idx(int'(win_idx), NUM_REQ));
        lock_d   = 1'b0;
      end
`else
      rr_ptr_d   = IDX_W'(next_idx(int'(win_idx), NUM_REQ));
`endif
    end
  end

  // State, data and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_src_q  <= '0;
      rr_ptr_q   <= '0;
`ifdef MUX_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      rr_ptr_q   <= rr_ptr_d;
`ifdef MUX_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

endmodule
